uart_tx_scheduler: RTL

- Arbitrates up to NUM_SRC packet sources for the single 64-bit UART transmitter and sequences each transfer.
- Sources are the data FIFO, config-read responses and test-pattern generator; each offers a 64-bit packet with a valid/ready handshake.
- The scheduler captures one packet, drives tx_data and ld_tx_data into the transmitter, and tracks tx_busy until the word has been fully sent.
- It sits between the packet builders and the UART TX, in the same clock domain as the transmitter's baud clock.

---
 rtl/uart_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/uart_tx_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_sched_pkg: shared types, defaults and parity helper for the UART  |
// | TX scheduler.                                  Revision: 1.0           |
// +-------------------------------------------------------------------------+
package uart_sched_pkg;

   localparam int c_DEF_WIDTH   = 64;
   localparam int c_DEF_NUM_SRC = 3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_DONE = 2'd2
   } sched_state_t;

   // Odd parity: the returned bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [c_DEF_WIDTH-2:0] d);
      return ~(^d);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick, scanning from ptr upward   |
// | modulo NUM_SRC.                                Revision: 1.0           |
// +-------------------------------------------------------------------------+
module rr_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int IDX_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      w_sum = '0;
      w_pos = '0;
      for (int off = 0; off < NUM_SRC; off++) begin
         // ptr and off are both below NUM_SRC, so one subtraction wraps.
         w_sum = {1'b0, ptr} + (IDX_W+1)'(off);
         if (w_sum >= (IDX_W+1)'(NUM_SRC)) begin
            w_sum = w_sum - (IDX_W+1)'(NUM_SRC);
         end
         w_pos = w_sum[IDX_W-1:0];
         if (!valid && req[w_pos]) begin
            valid        = 1'b1;
            grant[w_pos] = 1'b1;
            idx          = w_pos;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_tx_scheduler: round-robin packet scheduler feeding one UART TX.   |
// | Option UART_TX_SCHED_PARITY_EN: insert odd parity in tx_data MSB.      |
// | Revision: 1.0                                                          |
// +-------------------------------------------------------------------------+
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int WIDTH   = c_DEF_WIDTH,
   parameter int NUM_SRC = c_DEF_NUM_SRC,
   parameter int CNT_W   = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_SRC-1:0]           src_valid,
   input  logic [NUM_SRC*WIDTH-1:0]     src_data,
   output logic [NUM_SRC-1:0]           src_ready,
   input  logic                         tx_busy,
   output logic [WIDTH-1:0]             tx_data,
   output logic                         ld_tx_data,
   output logic [$clog2(NUM_SRC)-1:0]   grant_id,
   output logic                         sched_busy,
   output logic [CNT_W-1:0]             pkt_count
);

   localparam int IDX_W = $clog2(NUM_SRC);

   sched_state_t        r_state;
   sched_state_t        w_state_nxt;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    w_ptr_nxt;
   logic [NUM_SRC-1:0]  w_arb_grant;
   logic [IDX_W-1:0]    w_arb_idx;
   logic                w_arb_valid;
   logic [WIDTH-1:0]    w_cap_data;
   logic [NUM_SRC-1:0]  w_ready_nxt;
   logic [WIDTH-1:0]    w_data_nxt;
   logic                w_ld_nxt;
   logic [IDX_W-1:0]    w_gid_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req   (src_valid),
      .ptr   (r_rr_ptr),
      .grant (w_arb_grant),
      .idx   (w_arb_idx),
      .valid (w_arb_valid)
   );

`ifdef UART_TX_SCHED_PARITY_EN
   assign w_cap_data = {odd_parity(src_data[w_arb_idx*WIDTH +: WIDTH-1]),
                        src_data[w_arb_idx*WIDTH +: WIDTH-1]};
`else
   assign w_cap_data = src_data[w_arb_idx*WIDTH +: WIDTH];
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_rr_ptr;
      w_ready_nxt = '0;
      w_data_nxt  = tx_data;
      w_ld_nxt    = ld_tx_data;
      w_gid_nxt   = grant_id;
      w_cnt_nxt   = pkt_count;
      case (r_state)
         IDLE: begin
            if (w_arb_valid && !tx_busy) begin
               w_state_nxt = LOAD;
               w_ready_nxt = w_arb_grant;
               w_data_nxt  = w_cap_data;
               w_gid_nxt   = w_arb_idx;
               w_ld_nxt    = 1'b1;
               w_ptr_nxt   = (w_arb_idx == IDX_W'(NUM_SRC-1)) ? '0 : w_arb_idx + 1'b1;
            end
         end
         // Strobe is held until the transmitter acknowledges by going busy.
         LOAD: begin
            if (tx_busy) begin
               w_ld_nxt    = 1'b0;
               w_state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               w_cnt_nxt   = pkt_count + 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_ld_nxt    = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_rr_ptr   <= '0;
         src_ready  <= '0;
         tx_data    <= '0;
         ld_tx_data <= 1'b0;
         grant_id   <= '0;
         sched_busy <= 1'b0;
         pkt_count  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_ptr_nxt;
         src_ready  <= w_ready_nxt;
         tx_data    <= w_data_nxt;
         ld_tx_data <= w_ld_nxt;
         grant_id   <= w_gid_nxt;
         sched_busy <= (w_state_nxt != IDLE);
         pkt_count  <= w_cnt_nxt;
      end
   end

endmodule
`default_nettype wire
